// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store.
// Sequences grant, RAM access, data capture and a one-cycle ack.
module ram_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_ack,
  output logic [DW-1:0] ls_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rw,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   wait_cnt;
  logic [SW-1:0]   starve;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic            lat_we;
  logic            lat_ls;
  logic [DW-1:0]   if_rdata_q;
  logic [DW-1:0]   ls_rdata_q;
  logic            if_win;
  logic            any_req;
  logic            done;

  assign any_req  = if_req | ls_req;
  assign if_win   = if_req & (~ls_req | (starve == SW'(STARVE_MAX)));
  assign done     = (wait_cnt == CW'(RAM_LAT - 1));
  assign if_rdata = if_rdata_q;
  assign ls_rdata = ls_rdata_q;

  // State, latched request, wait/starve counters and read data capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      starve     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
      lat_ls     <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            lat_ls    <= ~if_win;
            lat_addr  <= if_win ? if_addr : ls_addr;
            lat_we    <= ~if_win & ls_we;
            lat_wdata <= if_win ? '0 : ls_wdata;
            wait_cnt  <= '0;
          end
          if (!if_req || if_win)
            starve <= '0;
          else if (starve != SW'(STARVE_MAX))
            starve <= starve + 1'b1;
        end
        ACCESS: begin
          if (done) begin
            if (!lat_ls)
              if_rdata_q <= ram_rdata;
            else if (!lat_we)
              ls_rdata_q <= ram_rdata;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and RAM/ack outputs decoded from the current state
  always_comb begin
    state_nx  = state;
    ram_addr  = '0;
    ram_rw    = 1'b0;
    ram_wdata = '0;
    if_ack    = 1'b0;
    ls_ack    = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (any_req)
          state_nx = ACCESS;
      end
      ACCESS: begin
        ram_addr  = lat_addr;
        ram_rw    = lat_we;
        ram_wdata = lat_we ? lat_wdata : '0;
        if (done)
          state_nx = RESP;
      end
      RESP: begin
        if_ack   = ~lat_ls;
        ls_ack   = lat_ls;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: vector table plus hand sequences,
// with a scoreboard of expected acks for the RAM_LAT=1 instance.
module tb_ram_port_arbiter;

  logic clk;
  logic reset;

  logic        if_req, ls_req, ls_we;
  logic [15:0] if_addr, ls_addr;
  logic [31:0] ls_wdata;
  logic        if_ack, ls_ack, ram_rw, busy;
  logic [31:0] if_rdata, ls_rdata, ram_wdata, ram_rdata;
  logic [15:0] ram_addr;

  logic        if_req3, ls_req3, ls_we3;
  logic [15:0] if_addr3, ls_addr3;
  logic [31:0] ls_wdata3;
  logic        if_ack3, ls_ack3, ram_rw3, busy3;
  logic [31:0] if_rdata3, ls_rdata3, ram_wdata3, ram_rdata3;
  logic [15:0] ram_addr3;

  logic [31:0] mem1 [0:65535];
  logic [31:0] mem3 [0:65535];
  logic [15:0] a1, a2;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        is_ls;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          is_ls;
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl [8];

  ram_port_arbiter #(.AW(16), .DW(32), .RAM_LAT(1), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .ram_addr(ram_addr), .ram_rw(ram_rw), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  ram_port_arbiter #(.AW(16), .DW(32), .RAM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
    .ls_req(ls_req3), .ls_we(ls_we3), .ls_addr(ls_addr3), .ls_wdata(ls_wdata3),
    .ls_ack(ls_ack3), .ls_rdata(ls_rdata3),
    .ram_addr(ram_addr3), .ram_rw(ram_rw3), .ram_wdata(ram_wdata3),
    .ram_rdata(ram_rdata3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata  = mem1[ram_addr];
  assign ram_rdata3 = mem3[a2];

  initial begin
    for (int i = 0; i < 65536; i++) mem1[i] = 32'h0;
    mem1[16'h0010] = 32'hA5A5_0001;
    forever begin
      @(posedge clk);
      if (ram_rw) mem1[ram_addr] <= ram_wdata;
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem3[i] = 32'h0;
    mem3[16'hFFFF] = 32'h1234_5678;
    a1 = 16'h0;
    a2 = 16'h0;
    forever begin
      @(posedge clk);
      if (ram_rw3) mem3[ram_addr3] <= ram_wdata3;
      a1 <= ram_addr3;
      a2 <= a1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got event want none", nm);
  endtask

  always @(negedge clk) begin
    if (if_ack || ls_ack) begin
      if (if_ack && ls_ack) fail("ack_overlap");
      if (sb.size() == 0) begin
        fail("sb_unexpected_ack");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_src", {31'h0, ls_ack}, {31'h0, e.is_ls});
        chk("sb_rdata", ls_ack ? ls_rdata : if_rdata, e.rdata);
      end
    end
  end

  task automatic run1(input vec_t v);
    int  k;
    int  rw_cyc;
    bit  seen;
    @(negedge clk);
    if (v.is_ls) begin
      ls_req   = 1'b1;
      ls_we    = v.we;
      ls_addr  = v.addr;
      ls_wdata = v.wdata;
    end else begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end
    sb.push_back('{v.is_ls, v.exp});
    @(posedge clk);
    #1;
    chk($sformatf("%s_addr", v.name), {16'h0, ram_addr}, {16'h0, v.addr});
    if_addr  = ~v.addr;
    ls_addr  = ~v.addr;
    ls_wdata = ~v.wdata;
    k = 0;
    rw_cyc = 0;
    seen = 1'b0;
    while (k < 12) begin
      if (ram_rw) begin
        rw_cyc++;
        chk($sformatf("%s_wdata", v.name), ram_wdata, v.wdata);
      end
      if (if_ack || ls_ack) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      k++;
    end
    if (!seen) fail($sformatf("%s_ack_timeout", v.name));
    else chk($sformatf("%s_lat", v.name), k + 2, 3);
    chk($sformatf("%s_rw", v.name), rw_cyc, (v.is_ls && v.we) ? 1 : 0);
    if_req = 1'b0;
    ls_req = 1'b0;
    ls_we  = 1'b0;
    @(posedge clk);
    #1;
    chk($sformatf("%s_idle", v.name), {busy, ram_rw, ram_addr}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  k;
    bit  seen;
    bit  addr_ok;
    vec_t v;

    tbl[0] = '{0, 0, 16'h0010, 32'h0,         32'hA5A5_0001, "fetch"};
    tbl[1] = '{1, 1, 16'h0200, 32'hDEAD_BEEF, 32'h0,         "store"};
    tbl[2] = '{1, 0, 16'h0200, 32'h0,         32'hDEAD_BEEF, "load"};
    tbl[3] = '{0, 0, 16'h0200, 32'h0,         32'hDEAD_BEEF, "fetch_st"};
    tbl[4] = '{1, 1, 16'h0000, 32'h0BAD_F00D, 32'hDEAD_BEEF, "store0"};
    tbl[5] = '{1, 0, 16'h0000, 32'h0,         32'h0BAD_F00D, "load0"};
    tbl[6] = '{1, 0, 16'h0010, 32'h0,         32'hA5A5_0001, "load_if"};
    tbl[7] = '{0, 0, 16'h0000, 32'h0,         32'h0BAD_F00D, "fetch0"};

    reset = 1'b1;
    if_req = 0; ls_req = 0; ls_we = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0;
    if_req3 = 0; ls_req3 = 0; ls_we3 = 0;
    if_addr3 = 0; ls_addr3 = 0; ls_wdata3 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {28'h0, if_ack, ls_ack, busy, ram_rw}, 32'h0);
    chk("rst_addr", {16'h0, ram_addr}, 32'h0);
    chk("rst_wdata", ram_wdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    chk("rst_ctl3", {28'h0, if_ack3, ls_ack3, busy3, ram_rw3}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run1(tbl[i]);

    @(negedge clk);
    if_addr = 16'h0010;
    ls_addr = 16'h0200;
    ls_we   = 1'b0;
    for (int i = 0; i < 6; i++)
      sb.push_back('{(i != 4), (i != 4) ? 32'hDEAD_BEEF : 32'hA5A5_0001});
    if_req = 1'b1;
    ls_req = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (if_ack || ls_ack) n++;
      if (n == 6) break;
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    chk("starve_acks", n, 6);
    @(posedge clk);
    #1;
    chk("starve_idle", {31'h0, busy}, 32'h0);

    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1;
    ls_addr = 16'h0300; ls_wdata = 32'h55AA_55AA;
    @(posedge clk);
    #1;
    chk("rst_mid_rw_pre", {31'h0, ram_rw}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rst_mid_rw", {31'h0, ram_rw}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    ls_req = 1'b0;
    ls_we  = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_nowrite", mem1[16'h0300], 32'h0);
    chk("rst_mid_ls_rdata", ls_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    v = '{0, 0, 16'h0010, 32'h0, 32'hA5A5_0001, "post_rst"};
    run1(v);

    @(negedge clk);
    ls_req3 = 1'b1;
    ls_we3 = 1'b0;
    ls_addr3 = 16'hFFFF;
    @(posedge clk);
    #1;
    ls_addr3 = 16'h1234;
    addr_ok = 1'b1;
    seen = 1'b0;
    k = 0;
    while (k < 12) begin
      if (ls_ack3) begin
        seen = 1'b1;
        break;
      end
      if (ram_addr3 != 16'hFFFF) addr_ok = 1'b0;
      @(posedge clk);
      #1;
      k++;
    end
    ls_req3 = 1'b0;
    if (!seen) fail("lat3_ack_timeout");
    else chk("lat3_lat", k + 2, 5);
    chk("lat3_addr_hold", {31'h0, addr_ok}, 32'h1);
    chk("lat3_rdata", ls_rdata3, 32'h1234_5678);
    chk("lat3_no_if_ack", {31'h0, if_ack3}, 32'h0);

    repeat (2) @(posedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
